// File: rtl/sprite_blit_pkg.sv
// Shared types for the sprite blitter: FSM states, request modes and the
// per-pixel tag header carried through the ROM-latency delay line.
package sprite_blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        MODE_DRAW  = 2'd0,
        MODE_ERASE = 2'd1,
        MODE_MOVE  = 2'd2
    } mode_e;

    localparam logic KIND_BG  = 1'b0;
    localparam logic KIND_SPR = 1'b1;

    typedef struct packed {
        logic valid;
        logic kind;
    } tag_hdr_t;

    // Full tag is {tag_hdr_t, x, y}.
    function automatic int unsigned tag_width(input int unsigned x_w, input int unsigned y_w);
        return 2 + x_w + y_w;
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Request handshake between a game-logic FSM (master) and the blitter (slave).
interface sprite_blitter_if #(
    parameter int unsigned nX = 10,
    parameter int unsigned nY = 9
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_mode;
    logic [nX-1:0] req_x;
    logic [nY-1:0] req_y;
    logic          done;

    modport master (output req_valid, req_mode, req_x, req_y, input req_ready, done);
    modport slave  (input req_valid, req_mode, req_x, req_y, output req_ready, done);
endinterface

// File: rtl/blit_delay_line.sv
// DEPTH-stage shift register that keeps pixel tags aligned with ROM read data.
module blit_delay_line #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/sprite_blitter.sv
// Request-driven sprite blitter: restores background under the old position,
// draws the sprite with colour-key transparency and clips at the screen edge.
module sprite_blitter
    import sprite_blit_pkg::*;
#(
    parameter int unsigned nX = 10,
    parameter int unsigned nY = 9,
    parameter int unsigned COLOR_DEPTH = 9,
    parameter int unsigned XSCREEN = 640,
    parameter int unsigned YSCREEN = 480,
    parameter int unsigned SPR_W = 60,
    parameter int unsigned SPR_H = 60,
    parameter int unsigned SPR_AW = 12,
    parameter int unsigned BG_AW = 19,
    parameter int unsigned ROM_LAT = 1,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = 9'b111_000_111
) (
    input  logic                   Clock,
    input  logic                   Reset,
    sprite_blitter_if.slave        req,
    output logic [SPR_AW-1:0]      spr_addr,
    input  logic [COLOR_DEPTH-1:0] spr_data,
    output logic [BG_AW-1:0]       bg_addr,
    input  logic [COLOR_DEPTH-1:0] bg_data,
    output logic [nX-1:0]          VGA_x,
    output logic [nY-1:0]          VGA_y,
    output logic [COLOR_DEPTH-1:0] VGA_color,
    output logic                   VGA_write
);
    localparam int unsigned PXW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned PYW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned DCW   = $clog2(ROM_LAT + 1);
    localparam int unsigned TAG_W = tag_width(nX, nY);

    localparam logic [PXW-1:0]   PX_LAST = PXW'(SPR_W - 1);
    localparam logic [PYW-1:0]   PY_LAST = PYW'(SPR_H - 1);
    localparam logic [DCW-1:0]   DC_LAST = DCW'(ROM_LAT);
    localparam logic [nX:0]      XS      = (nX+1)'(XSCREEN);
    localparam logic [nY:0]      YS      = (nY+1)'(YSCREEN);
    localparam logic [BG_AW-1:0] XS_BG   = BG_AW'(XSCREEN);

    state_e         state;
    mode_e          mode_r;
    logic [nX-1:0]  prev_x, cur_x;
    logic [nY-1:0]  prev_y, cur_y;
    logic           prev_valid;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [DCW-1:0] drain_cnt;
    logic           done_r;

    logic             in_erase, on_screen;
    logic [nX:0]      sx;
    logic [nY:0]      sy;
    tag_hdr_t         hdr_in, hdr_out;
    logic [TAG_W-1:0] tag_in, tag_out;
    logic [nX-1:0]    out_x;
    logic [nY-1:0]    out_y;

    assign req.req_ready = (state == ST_IDLE);
    assign req.done      = done_r;

    // Issue stage: one pixel per cycle, coordinates one bit wider so clipping sees overflow.
    always_comb begin
        in_erase  = (state == ST_ERASE);
        sx        = (nX+1)'(in_erase ? prev_x : cur_x) + (nX+1)'(px);
        sy        = (nY+1)'(in_erase ? prev_y : cur_y) + (nY+1)'(py);
        on_screen = ((state == ST_ERASE) || (state == ST_DRAW)) && (sx < XS) && (sy < YS);
        spr_addr  = '0;
        bg_addr   = '0;
        if (on_screen) begin
            if (in_erase) bg_addr  = BG_AW'(sy) * XS_BG + BG_AW'(sx);
            else          spr_addr = SPR_AW'(py) * SPR_AW'(SPR_W) + SPR_AW'(px);
        end
        hdr_in.valid = on_screen;
        hdr_in.kind  = in_erase ? KIND_BG : KIND_SPR;
        tag_in       = {hdr_in, sx[nX-1:0], sy[nY-1:0]};
    end

    blit_delay_line #(.WIDTH(TAG_W), .DEPTH(ROM_LAT)) u_tags (
        .clk (Clock),
        .rst (Reset),
        .d   (tag_in),
        .q   (tag_out)
    );

    assign hdr_out = tag_out[TAG_W-1 -: 2];
    assign out_x   = tag_out[nX+nY-1:nY];
    assign out_y   = tag_out[nY-1:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            VGA_write <= 1'b0;
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
        end else begin
            VGA_write <= hdr_out.valid &&
                         ((hdr_out.kind == KIND_BG) || (spr_data != TRANSPARENT_COLOR));
            if (hdr_out.valid) begin
                VGA_x     <= out_x;
                VGA_y     <= out_y;
                VGA_color <= (hdr_out.kind == KIND_SPR) ? spr_data : bg_data;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            mode_r     <= MODE_DRAW;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            cur_x      <= '0;
            cur_y      <= '0;
            px         <= '0;
            py         <= '0;
            drain_cnt  <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req.req_valid) begin
                        cur_x     <= req.req_x;
                        cur_y     <= req.req_y;
                        px        <= '0;
                        py        <= '0;
                        drain_cnt <= '0;
                        if (req.req_mode == MODE_ERASE) begin
                            mode_r <= MODE_ERASE;
                            state  <= prev_valid ? ST_ERASE : ST_DRAIN;
                        end else if (req.req_mode == MODE_MOVE) begin
                            mode_r <= MODE_MOVE;
                            state  <= prev_valid ? ST_ERASE : ST_DRAW;
                        end else begin
                            mode_r <= MODE_DRAW;
                            state  <= ST_DRAW;
                        end
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    if (px == PX_LAST) begin
                        px <= '0;
                        if (py == PY_LAST) begin
                            py <= '0;
                            // MOVE chains straight into DRAW; tags keep the two phases apart.
                            if (state == ST_ERASE && mode_r == MODE_MOVE) state <= ST_DRAW;
                            else                                          state <= ST_DRAIN;
                        end else begin
                            py <= py + 1'b1;
                        end
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DC_LAST) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b1;
                        if (mode_r == MODE_ERASE) begin
                            prev_valid <= 1'b0;
                        end else begin
                            prev_x     <= cur_x;
                            prev_y     <= cur_y;
                            prev_valid <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter against a pixel-list reference model.
module tb_sprite_blitter;
    localparam int unsigned NX = 10, NY = 9, CD = 9;
    localparam int SW = 4, SH = 2, LAT = 2;
    localparam logic [8:0] KEY = 9'h1C7;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    sprite_blitter_if #(.nX(NX), .nY(NY)) req_bus ();

    logic [11:0] spr_addr;
    logic [8:0]  spr_data;
    logic [18:0] bg_addr;
    logic [8:0]  bg_data;
    logic [9:0]  VGA_x;
    logic [8:0]  VGA_y;
    logic [8:0]  VGA_color;
    logic        VGA_write;

    sprite_blitter #(.SPR_W(SW), .SPR_H(SH), .ROM_LAT(LAT)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req       (req_bus),
        .spr_addr  (spr_addr),
        .spr_data  (spr_data),
        .bg_addr   (bg_addr),
        .bg_data   (bg_data),
        .VGA_x     (VGA_x),
        .VGA_y     (VGA_y),
        .VGA_color (VGA_color),
        .VGA_write (VGA_write)
    );

    function automatic logic [8:0] bg_color(input int a);
        return 9'((a * 7) ^ (a >> 4));
    endfunction

    // ROM models with LAT-cycle read latency
    logic [8:0] spr_mem [SW*SH];
    logic [8:0] spr_pipe [LAT];
    logic [8:0] bg_pipe [LAT];
    always @(posedge Clock) begin
        spr_pipe[0] <= spr_mem[int'(spr_addr) % (SW*SH)];
        bg_pipe[0]  <= bg_color(int'(bg_addr));
        for (int i = 1; i < LAT; i++) begin
            spr_pipe[i] <= spr_pipe[i-1];
            bg_pipe[i]  <= bg_pipe[i-1];
        end
    end
    assign spr_data = spr_pipe[LAT-1];
    assign bg_data  = bg_pipe[LAT-1];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_wr(input int c, input int x, input int y, input int col);
        return {16'(c), 16'(x), 16'(y), 16'(col)};
    endfunction

    // Reference state: where the sprite currently sits on screen
    int m_px = 0, m_py = 0;
    bit m_pv = 1'b0;

    task automatic drive_req(input int mode, input int x, input int y);
        @(negedge Clock);
        check("ready_before_req", {63'd0, req_bus.req_ready}, 64'd1);
        req_bus.req_valid = 1'b1;
        req_bus.req_mode  = 2'(mode);
        req_bus.req_x     = 10'(x);
        req_bus.req_y     = 9'(y);
        @(posedge Clock);
        #1 req_bus.req_valid = 1'b0;
    endtask

    task automatic run_req(input int mode, input int x, input int y, input string name);
        logic [63:0] exp_q[$];
        logic [63:0] obs_q[$];
        int exp_bg[int];
        int exp_spr[int];
        int obs_bg[64];
        int obs_spr[64];
        int n = 0;
        int done_c = 0;
        bit do_erase = ((mode == 1) || (mode == 2)) && m_pv;
        bit do_draw  = (mode != 1);
        int cmp;

        if (do_erase)
            for (int yy = 0; yy < SH; yy++)
                for (int xx = 0; xx < SW; xx++) begin
                    int sx = m_px + xx;
                    int sy = m_py + yy;
                    n++;
                    if (sx < 640 && sy < 480) begin
                        exp_bg[n] = sy * 640 + sx;
                        exp_q.push_back(pack_wr(n + LAT + 1, sx, sy, int'(bg_color(sy * 640 + sx))));
                    end else begin
                        exp_bg[n] = 0;
                    end
                end
        if (do_draw)
            for (int yy = 0; yy < SH; yy++)
                for (int xx = 0; xx < SW; xx++) begin
                    int sx = x + xx;
                    int sy = y + yy;
                    int i  = yy * SW + xx;
                    n++;
                    if (sx < 640 && sy < 480) begin
                        exp_spr[n] = i;
                        if (spr_mem[i] != KEY)
                            exp_q.push_back(pack_wr(n + LAT + 1, sx, sy, int'(spr_mem[i])));
                    end else begin
                        exp_spr[n] = 0;
                    end
                end

        drive_req(mode, x, y);
        for (int c = 1; c < 64; c++) begin
            @(negedge Clock);
            obs_bg[c]  = int'(bg_addr);
            obs_spr[c] = int'(spr_addr);
            if (VGA_write) obs_q.push_back(pack_wr(c, int'(VGA_x), int'(VGA_y), int'(VGA_color)));
            if (req_bus.done) begin
                done_c = c;
                break;
            end
        end

        check({name, "_done_cycle"}, 64'(done_c), 64'(n + LAT + 2));
        check({name, "_ready_at_done"}, {63'd0, req_bus.req_ready}, 64'd1);
        check({name, "_write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < cmp; i++) check({name, "_write"}, obs_q[i], exp_q[i]);
        foreach (exp_bg[k])  check({name, "_bg_addr"},  64'(obs_bg[k]),  64'(exp_bg[k]));
        foreach (exp_spr[k]) check({name, "_spr_addr"}, 64'(obs_spr[k]), 64'(exp_spr[k]));

        @(negedge Clock);
        check({name, "_done_pulse"}, {63'd0, req_bus.done}, 64'd0);

        if (mode == 1) m_pv = 1'b0;
        else begin
            m_px = x;
            m_py = y;
            m_pv = 1'b1;
        end
    endtask

    task automatic fill_sprite(input int key_chance);
        for (int i = 0; i < SW*SH; i++) begin
            spr_mem[i] = 9'($urandom_range(0, 511));
            if (spr_mem[i] == KEY) spr_mem[i] = spr_mem[i] ^ 9'h001;
            if (key_chance > 0 && $urandom_range(0, key_chance - 1) == 0) spr_mem[i] = KEY;
        end
    endtask

    initial begin
        req_bus.req_valid = 1'b0;
        req_bus.req_mode  = 2'd0;
        req_bus.req_x     = '0;
        req_bus.req_y     = '0;
        fill_sprite(0);
        repeat (3) @(negedge Clock);
        check("rst_ready", {63'd0, req_bus.req_ready}, 64'd1);
        check("rst_write", {63'd0, VGA_write}, 64'd0);
        check("rst_done", {63'd0, req_bus.done}, 64'd0);
        check("rst_vga", {VGA_x, VGA_y, VGA_color}, 64'd0);
        check("rst_addr", {spr_addr, bg_addr}, 64'd0);
        Reset = 1'b0;
        m_pv = 1'b0;

        run_req(1, 5, 5, "erase_no_prev");
        run_req(0, 10, 20, "draw_opaque");
        spr_mem[1] = KEY;
        spr_mem[6] = KEY;
        run_req(0, 10, 20, "draw_keyed");
        fill_sprite(0);
        run_req(2, 50, 20, "move");
        run_req(0, 638, 479, "draw_clip");

        // Abort an erase mid-flight with reset
        run_req(0, 100, 100, "draw_pre_rst");
        drive_req(1, 0, 0);
        repeat (6) @(negedge Clock);
        check("rst_mid_write_before", {63'd0, VGA_write}, 64'd1);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_write_drop", {63'd0, VGA_write}, 64'd0);
        check("rst_mid_done", {63'd0, req_bus.done}, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        m_pv = 1'b0;
        @(negedge Clock);
        check("rst_mid_ready", {63'd0, req_bus.req_ready}, 64'd1);
        run_req(2, 200, 50, "move_after_rst");

        for (int t = 0; t < 30; t++) begin
            int x, y, mode;
            fill_sprite(4);
            mode = $urandom_range(0, 3);
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(630, 700) : $urandom_range(0, 639);
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 511) : $urandom_range(0, 479);
            run_req(mode, x, y, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite engine for the VGA write port. It generalises the fixed-lane, fixed-size player drawer into a request-driven blitter. It accepts arbitrary (x, y) targets and any sprite size and ROM latency. It restores the background under the old position, draws the sprite with colour-key transparency and clips at the screen edge. It sits between game-logic FSMs (player, obstacles) and the VGA adapter write port; the sprite and background ROMs are external and addressed by this block.

## Interface
Parameters:
- nX, 10, VGA x width
- nY, 9, VGA y width
- COLOR_DEPTH, 9, pixel colour width (RRR_GGG_BBB)
- XSCREEN, 640, screen width in pixels
- YSCREEN, 480, screen height in pixels
- SPR_W, 60, sprite width in pixels
- SPR_H, 60, sprite height in pixels
- SPR_AW, 12, sprite ROM address width
- BG_AW, 19, background ROM address width
- ROM_LAT, 1, read latency of both ROMs in cycles (≥1)
- TRANSPARENT_COLOR, 9'b111_000_111, colour key that is never drawn

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a Clock edge where valid&&ready
- req_mode  in  2  0 = DRAW, 1 = ERASE, 2 = MOVE (erase, then draw); 3 is treated as DRAW
- req_x  in  nX  new sprite top-left x
- req_y  in  nY  new sprite top-left y
- spr_addr  out  SPR_AW  sprite ROM address
- spr_data  in  COLOR_DEPTH  sprite ROM data, ROM_LAT cycles after spr_addr
- bg_addr  out  BG_AW  background ROM address
- bg_data  in  COLOR_DEPTH  background ROM data, ROM_LAT cycles after bg_addr
- VGA_x  out  nX  registered pixel x
- VGA_y  out  nY  registered pixel y
- VGA_color  out  COLOR_DEPTH  registered pixel colour
- VGA_write  out  1  registered write strobe
- done  out  1  one-cycle pulse when a request is fully written

## Operation
- States: IDLE, ERASE, DRAW, DRAIN.
- Internal registers: prev_x, prev_y, prev_valid (reset 0), cur_x, cur_y, scan counters px (0..SPR_W-1) and py (0..SPR_H-1).
- On accept, latch req_x/req_y into cur_x/cur_y:
  - DRAW goes to DRAW.
  - ERASE and MOVE go to ERASE if prev_valid; otherwise ERASE goes to DRAIN and MOVE goes to DRAW.
- ERASE and DRAW scan raster order, one pixel per cycle, x fastest.
- ERASE:
  - Scans the rectangle at prev_x/prev_y.
  - bg_addr = (prev_y+py)*XSCREEN + (prev_x+px).
  - Writes are always issued for erase pixels, using bg_data.
  - On the last pixel, MOVE goes to DRAW (px, py cleared) and ERASE goes to DRAIN.
- DRAW:
  - spr_addr = py*SPR_W + px.
  - The write is suppressed when spr_data == TRANSPARENT_COLOR.
  - The last pixel goes to DRAIN.
- Clipping:
  - Screen coordinates are computed at nX+1 / nY+1 bits.
  - A pixel with x ≥ XSCREEN or y ≥ YSCREEN is issued with tag valid=0 and ROM addresses forced to 0.
  - Such a pixel is never written.
- Pipeline:
  - Each issued pixel carries the tag {valid, kind, x, y} through a ROM_LAT-deep delay line.
  - The output register then samples the ROM data that matches the tag.
  - ERASE→DRAW switching needs no bubble, because the kind tag selects bg_data or spr_data per pixel.
- DRAIN:
  - Waits until the delay line and output register are empty (ROM_LAT+1 cycles).
  - Then pulses done and returns to IDLE.
- prev_x, prev_y and prev_valid are updated at done:
  - DRAW and MOVE set them to cur_x/cur_y and set prev_valid to 1.
  - ERASE clears prev_valid.
- req_valid is ignored outside IDLE; no queuing.

## Timing
- Reset values: req_ready 1 (IDLE), VGA_write 0, VGA_x/VGA_y/VGA_color 0, done 0, spr_addr/bg_addr 0, pipeline tags invalid, prev_valid 0.
- Accept at edge 0. The first address is issued in cycle 1.
- The pixel issued in cycle k is visible on the VGA_* outputs in cycle k+ROM_LAT+1.
- N = pixels scanned: SPR_W*SPR_H for DRAW or ERASE, 2*SPR_W*SPR_H for MOVE with prev_valid, 0 for ERASE with no prev.
- The last output is visible in cycle N+ROM_LAT+1. done and req_ready are high in cycle N+ROM_LAT+2.
- For the zero-pixel case, done is high in cycle ROM_LAT+2.
- Reset asserted mid-request: immediate abort, VGA_write drops asynchronously, prev_valid is cleared, no done.

## Structure
- Package sprite_blit_pkg: state encoding, req_mode constants (MODE_DRAW/ERASE/MOVE), pixel tag struct/width.
- One sub-module, blit_delay_line: parametrised ROM_LAT-deep shift register of tags, with an async clear.

## Test plan
Small configuration for all scenarios: SPR_W=4, SPR_H=2, ROM_LAT=2, ROM models with 2-cycle latency.
- DRAW at (10,20), sprite all opaque → 8 writes at (10..13, 20..21) in raster order, first in cycle 4, done in cycle 12.
- DRAW with sprite pixels 1 and 6 equal to 9'h1C7 → only 6 writes, at the correct coordinates and colours.
- MOVE to (50,20) after the first test → 8 background writes at the old rectangle, with colours equal to bg model[y*640+x], then 8 sprite writes at the new one. done in cycle 20.
- ERASE immediately after reset → no writes, done in cycle 4, prev_valid stays 0.
- DRAW at (638,479) → only pixel (638,479) and pixel (639,479) are written; the clipped pixels issue addresses 0.
- Reset asserted during ERASE → VGA_write is 0 in the same cycle, req_ready is 1 after release, and a following MOVE behaves as a DRAW.
